// File: rtl/shift_pkg.sv
// Shared encodings and defaults for the shift/rotate unit feeding the SZCV flag register.
package shift_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned AMT_W_DEF = 4;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SLR = 2'b01;
  localparam logic [1:0] SH_SRL = 2'b10;
  localparam logic [1:0] SH_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; shared by the iterative and barrel paths.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] next_value,
  output logic             carry
);

  always_comb begin
    next_value = value;
    carry      = 1'b0;
    unique case (op)
      SH_SLL: begin
        next_value = {value[WIDTH-2:0], 1'b0};
        carry      = value[WIDTH-1];
      end
      SH_SLR: begin
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
        carry      = value[WIDTH-1];
      end
      SH_SRL: begin
        next_value = {1'b0, value[WIDTH-1:1]};
        carry      = value[0];
      end
      SH_SRA: begin
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
        carry      = value[0];
      end
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Shift/rotate unit producing result plus SZCV flags and a load strobe for the flag register.
// Iterative (1 bit/cycle) by default; define SHIFT_SEQ_BARREL_EN for a single-cycle barrel path.
module shift_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] operand,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             ld_szcv,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       szcv_out
);

  state_e           state_q, state_d;
  logic             load_done;
  logic [WIDTH-1:0] fin_value;
  logic             fin_carry;
  logic [3:0]       fin_szcv;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       szcv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef SHIFT_SEQ_BARREL_EN
  // One stage per possible shift count; stage i is bypassed when i >= amt.
  localparam int unsigned Stages = (1 << AMT_W) - 1;

  logic [WIDTH-1:0] stage_value [Stages+1];
  logic             stage_carry [Stages+1];

  assign stage_value[0] = operand;
  assign stage_carry[0] = 1'b0;

  for (genvar i = 0; i < Stages; i++) begin : g_stage
    logic [WIDTH-1:0] nv;
    logic             nc;
    shift_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .value     (stage_value[i]),
      .op        (op),
      .next_value(nv),
      .carry     (nc)
    );
    assign stage_value[i+1] = (AMT_W'(i) < amt) ? nv : stage_value[i];
    assign stage_carry[i+1] = (AMT_W'(i) < amt) ? nc : stage_carry[i];
  end

  assign fin_value = stage_value[Stages];
  assign fin_carry = stage_carry[Stages];

  always_comb begin
    state_d   = state_q;
    load_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_DONE;
          load_done = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
`else
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] step_value;
  logic             step_carry;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .value     (val_q),
    .op        (op_q),
    .next_value(step_value),
    .carry     (step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      val_q <= '0;
      op_q  <= SH_SLL;
    end else begin
      cnt_q <= cnt_d;
      val_q <= val_d;
      op_q  <= op_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (amt != '0) begin
            state_d = ST_SHIFT;
          end else begin
            state_d   = ST_DONE;
            load_done = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == AMT_W'(1)) begin
          state_d   = ST_DONE;
          load_done = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    val_d = val_q;
    op_d  = op_q;
    if (state_q == ST_IDLE && start) begin
      val_d = operand;
      op_d  = op;
      cnt_d = amt;
    end else if (state_q == ST_SHIFT) begin
      if (abort) begin
        cnt_d = '0;
      end else begin
        val_d = step_value;
        cnt_d = cnt_q - AMT_W'(1);
      end
    end
  end

  // amt==0 completes straight from IDLE with the untouched operand and no carry.
  assign fin_value = (state_q == ST_IDLE) ? operand : step_value;
  assign fin_carry = (state_q == ST_IDLE) ? 1'b0 : step_carry;
`endif

  always_comb begin
    fin_szcv         = '0;
    fin_szcv[FLAG_S] = fin_value[WIDTH-1];
    fin_szcv[FLAG_Z] = (fin_value == '0);
    fin_szcv[FLAG_C] = fin_carry;
    fin_szcv[FLAG_V] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      szcv_q   <= '0;
    end else if (load_done) begin
      result_q <= fin_value;
      szcv_q   <= fin_szcv;
    end
  end

  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    ld_szcv = (state_q == ST_DONE);
  end

  assign result   = result_q;
  assign szcv_out = szcv_q;

endmodule
